// File: rtl/blinky_ctr_param.sv
// Prescaled LED counter with up/down/ping-pong/hold modes, load, wrap or saturate,
// and binary or Gray-coded registered LED output plus step/wrap pulses.
module blinky_ctr_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned GRAY_OUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] leds,
  output logic             tick,
  output logic             wrap
);

  localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             step;

  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    step    = en && (presc_q == PRE_LAST);

    if (load) begin
      count_d = load_val;
      presc_d = '0;
      dir_d   = (load_val == CNT_MAX) ? DIR_DOWN : DIR_UP;
    end else if (en) begin
      if (!step) begin
        presc_d = presc_q + PW'(1);
      end else begin
        presc_d = '0;
        tick_d  = 1'b1;
        case (mode)
          MODE_UP: begin
            if (count_q != CNT_MAX) begin
              count_d = count_q + WIDTH'(1);
            end else if (SATURATE == 0) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end
          end
          MODE_DOWN: begin
            if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end else if (SATURATE == 0) begin
              count_d = CNT_MAX;
              wrap_d  = 1'b1;
            end
          end
          MODE_PING: begin
            // Turn-around reflects off the end value, so each end is shown for one step only.
            if (dir_q == DIR_UP) begin
              if (count_q == CNT_MAX) begin
                dir_d   = DIR_DOWN;
                count_d = CNT_MAX - WIDTH'(1);
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q + WIDTH'(1);
              end
            end else begin
              if (count_q == '0) begin
                dir_d   = DIR_UP;
                count_d = WIDTH'(1);
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end
          end
          MODE_HOLD: begin
            count_d = count_q;
          end
          default: begin
            count_d = count_q;
          end
        endcase
      end
    end

    leds_d = (GRAY_OUT != 0) ? (count_d ^ (count_d >> 1)) : count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      presc_q <= '0;
      dir_q   <= DIR_UP;
      leds_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      leds_q  <= leds_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign leds = leds_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule
